regfile_dump_reader: RTL

Debug read-out engine for the multi-cycle CPU datapath's 32-entry register file. After a one-cycle `start` pulse it drives the file's read-address port through entries 0..NUM-1. It captures each combinational read result and streams it out as (address, data) words over a valid/ready handshake, then pulses `done`. It connects to one read port of the register file, or a muxed copy of one, and to a host/trace sink.

---
 rtl/regdump_pkg.sv | 22 ++
 rtl/regdump_xor_acc.sv | 23 ++
 rtl/regfile_dump_reader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump engine.
// REGDUMP_CHECKSUM_EN adds the CSUM state used by the trailing XOR checksum word.
package regdump_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM        = 32;

    // Address tag of the checksum word; sliced down to ADDR_WIDTH by the user.
    localparam logic [31:0] CSUM_MARK = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_SEND = 3'd2,
`ifdef REGDUMP_CHECKSUM_EN
        S_CSUM = 3'd3,
`endif
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/regdump_xor_acc.sv
// XOR accumulator that folds accepted dump words into a running checksum.
// Only instantiated when REGDUMP_CHECKSUM_EN is defined.
module regdump_xor_acc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (en)
            acc <= acc ^ din;
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks the register file read port over entries 0..NUM-1 and streams (addr, data) words.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum word tagged with an all-ones address.
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM        = DEF_NUM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [WIDTH-1:0]      rf_rdata,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [WIDTH-1:0]      dump_data,
    output logic                  done
);

    localparam int IDX_W = ADDR_WIDTH + 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             hs;
    logic             last_reg;
    logic             csum_q;

    assign hs       = dump_valid & dump_ready;
    assign last_reg = (idx_q == IDX_W'(NUM - 1));

`ifdef REGDUMP_CHECKSUM_EN
    logic [WIDTH-1:0] acc;

    regdump_xor_acc #(.WIDTH(WIDTH)) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == S_IDLE && start),
        .en    (state_q == S_SEND && hs && !csum_q),
        .din   (dump_data),
        .acc   (acc)
    );

    // Marks that the word in SEND is the checksum, so its handshake ends the dump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csum_q <= 1'b0;
        else if (state_q == S_IDLE)
            csum_q <= 1'b0;
        else if (state_q == S_CSUM)
            csum_q <= 1'b1;
    end
`else
    assign csum_q = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        case (state_q)
            S_IDLE: if (start) state_d = S_READ;
            S_READ: state_d = S_SEND;
            S_SEND: begin
                if (hs) begin
                    if (csum_q)
                        state_d = S_DONE;
                    else if (!last_reg)
                        state_d = S_READ;
                    else
`ifdef REGDUMP_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: state_d = S_SEND;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            rf_raddr   <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx_q    <= '0;
                        rf_raddr <= '0;
                    end
                end
                S_READ: begin
                    dump_data  <= rf_rdata;
                    dump_addr  <= rf_raddr;
                    dump_valid <= 1'b1;
                end
                S_SEND: begin
                    if (hs) begin
                        dump_valid <= 1'b0;
                        if (!last_reg && !csum_q) begin
                            idx_q    <= idx_q + 1'b1;
                            rf_raddr <= ADDR_WIDTH'(idx_q + 1'b1);
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                S_CSUM: begin
                    dump_addr  <= CSUM_MARK[ADDR_WIDTH-1:0];
                    dump_data  <= acc;
                    dump_valid <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
